// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: zero-latency hit path toward the fetch stage,
// stall plus 4-word line refill over a req/ack word bus on a miss.
module icache_dm #(
    parameter int INDEX_W = 6,
    parameter int WORDS   = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_ce,
    input  logic [31:0]      cpu_addr,
    output logic [31:0]      cpu_inst,
    output logic             stall_req,
    input  logic             flush,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int LINES  = 1 << INDEX_W;
    localparam int BASE_W = 28;
    localparam int TAG_W  = BASE_W - INDEX_W;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t             state_reg, state_next;
    logic               mem_req_reg, mem_req_next;
    logic [31:0]        mem_addr_reg, mem_addr_next;
    logic [CNT_W-1:0]   miss_cnt_reg, miss_cnt_next;
    logic [1:0]         cnt_reg, cnt_next;
    logic               discard_reg, discard_next;
    logic [BASE_W-1:0]  base_reg, base_next;
    logic [LINES-1:0]   valid_reg, valid_next;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES*WORDS];

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_index;
    logic [1:0]         addr_off;
    logic               unused_addr_bits;

    assign addr_tag         = cpu_addr[31:INDEX_W+4];
    assign addr_index       = cpu_addr[INDEX_W+3:4];
    assign addr_off         = cpu_addr[3:2];
    assign unused_addr_bits = ^cpu_addr[1:0];

    logic               hit;
    logic               miss_start;
    logic               fill_we;
    logic               fill_done;
    logic [1:0]         cnt_inc;
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;

    assign hit        = cpu_ce & valid_reg[addr_index] & (tag_mem[addr_index] == addr_tag);
    assign miss_start = (state_reg == IDLE) & cpu_ce & ~hit;
    assign fill_we    = (state_reg == REFILL) & mem_ack;
    assign fill_done  = fill_we & (cnt_reg == 2'd3);
    assign cnt_inc    = cnt_reg + 2'd1;
    assign fill_idx   = base_reg[INDEX_W-1:0];
    assign fill_tag   = base_reg[BASE_W-1:INDEX_W];

    // The target line is invalidated when its refill starts so a partially
    // overwritten line can never hit; flush overrides everything.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        assign valid_next[gi] = flush ? 1'b0 :
                                (fill_done && fill_idx == INDEX_W'(gi)) ? ~discard_reg :
                                (miss_start && addr_index == INDEX_W'(gi)) ? 1'b0 :
                                valid_reg[gi];
    end

    always_comb begin
        state_next    = state_reg;
        mem_req_next  = mem_req_reg;
        mem_addr_next = mem_addr_reg;
        miss_cnt_next = miss_cnt_reg;
        cnt_next      = cnt_reg;
        discard_next  = discard_reg;
        base_next     = base_reg;
        case (state_reg)
            IDLE: begin
                if (miss_start) begin
                    base_next     = {addr_tag, addr_index};
                    cnt_next      = 2'd0;
                    mem_req_next  = 1'b1;
                    mem_addr_next = {addr_tag, addr_index, 4'b0000};
                    if (miss_cnt_reg != {CNT_W{1'b1}}) begin
                        miss_cnt_next = miss_cnt_reg + CNT_W'(1);
                    end
                    state_next    = REFILL;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    cnt_next      = cnt_inc;
                    mem_addr_next = {base_reg, cnt_inc, 2'b00};
                end
                // A flush seen mid-refill makes the finished line land invalid.
                if (fill_done) begin
                    mem_req_next = 1'b0;
                    discard_next = 1'b0;
                    state_next   = IDLE;
                end else if (flush) begin
                    discard_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= 32'd0;
            miss_cnt_reg <= '0;
            cnt_reg      <= 2'd0;
            discard_reg  <= 1'b0;
            base_reg     <= '0;
            valid_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            mem_req_reg  <= mem_req_next;
            mem_addr_reg <= mem_addr_next;
            miss_cnt_reg <= miss_cnt_next;
            cnt_reg      <= cnt_next;
            discard_reg  <= discard_next;
            base_reg     <= base_next;
            valid_reg    <= valid_next;
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[{fill_idx, cnt_reg}] <= mem_rdata;
        end
        if (fill_done) begin
            tag_mem[fill_idx] <= fill_tag;
        end
    end

    assign cpu_inst  = (rst && hit) ? data_mem[{addr_index, addr_off}] : 32'd0;
    assign stall_req = rst & ((state_reg == REFILL) | (cpu_ce & ~hit));
    assign mem_req   = mem_req_reg;
    assign mem_addr  = mem_addr_reg;
    assign miss_cnt  = miss_cnt_reg;

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed sequences, a hit table and random fetches
// checked against a line-level cache model and a static instruction memory.
module tb_icache_dm;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          cpu_ce;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_inst;
    logic          stall_req;
    logic          flush;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic [CW-1:0] miss_cnt;

    icache_dm #(.INDEX_W(6), .WORDS(4), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_ce    (cpu_ce),
        .cpu_addr  (cpu_addr),
        .cpu_inst  (cpu_inst),
        .stall_req (stall_req),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .miss_cnt  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: what each line holds, and the raw number of misses.
    bit m_valid [64];
    int m_tag   [64];
    int m_misses;

    // Memory responder state.
    int          ack_period = 1;
    int          ack_ctr    = 0;
    logic [31:0] ack_q [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (w < 32'h10) return ((w >> 2) + 32'd1) * 32'h11;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int sat_cnt(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    task automatic cycle(input logic ce, input logic [31:0] a, input logic fl);
        @(posedge clk);
        #1;
        cpu_ce   = ce;
        cpu_addr = a;
        flush    = fl;
        @(negedge clk);
    endtask

    // Acks every ack_period-th cycle of an outstanding request; outside a
    // request it toggles mem_ack randomly, which the cache must ignore.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (rst && mem_req) begin
                if (ack_ctr >= ack_period - 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    ack_q.push_back(mem_addr);
                    ack_ctr   = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    ack_ctr++;
                end
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
                ack_ctr   = 0;
            end
        end
    end

    // One complete fetch: hold the address until the stall drops, then
    // compare latency, delivered word, refill addresses and miss count.
    task automatic do_fetch(input logic [31:0] a, input int p);
        int          ix, tg, n_stall, addr_bad, exp_stall;
        logic        exp_hit, done;
        logic [31:0] base;
        ix       = int'((a >> 4) & 32'h3F);
        tg       = int'(a >> 10);
        exp_hit  = m_valid[ix] && (m_tag[ix] == tg);
        base     = a & ~32'hF;
        ack_period = p;
        ack_q.delete();
        n_stall  = 0;
        addr_bad = 0;
        done     = 1'b0;
        for (int c = 0; c < 200; c++) begin
            cycle(1'b1, a, 1'b0);
            if (!stall_req) begin
                done = 1'b1;
                break;
            end
            n_stall++;
            if (c > 0) begin
                if (mem_req !== 1'b1) addr_bad++;
                if (mem_addr !== base + 32'(4 * (ack_q.size() - (mem_ack ? 1 : 0)))) addr_bad++;
            end
        end
        exp_stall = exp_hit ? 0 : 1 + 4 * p;
        chk("fetch_done", 32'(done), 32'd1);
        chk("stall_cycles", n_stall, exp_stall);
        chk("inst", cpu_inst, mem_word(a));
        chk("ack_count", ack_q.size(), exp_hit ? 0 : 4);
        for (int i = 0; i < ack_q.size(); i++) begin
            if (ack_q[i] !== base + 32'(4 * i)) addr_bad++;
        end
        chk("refill_addr", addr_bad, 0);
        if (!exp_hit) begin
            m_valid[ix] = 1'b1;
            m_tag[ix]   = tg;
            m_misses++;
        end
        chk("miss_cnt", 32'(miss_cnt), sat_cnt(m_misses));
        $display("fetch addr=%h period=%0d hit=%0d stall=%0d inst=%h miss_cnt=%0d",
                 a, p, exp_hit, n_stall, cpu_inst, miss_cnt);
    endtask

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] inst;
        logic        stall;
    } vec_t;

    vec_t tab [6];

    initial begin
        int          n_stall, exp_m;
        logic        flushed, fl;
        logic [31:0] a;

        tab[0] = '{1'b1, 32'h0000_0000, 32'h0000_0011, 1'b0};
        tab[1] = '{1'b1, 32'h0000_0008, 32'h0000_0033, 1'b0};
        tab[2] = '{1'b1, 32'h0000_000C, 32'h0000_0044, 1'b0};
        tab[3] = '{1'b1, 32'h0000_0004, 32'h0000_0022, 1'b0};
        tab[4] = '{1'b1, 32'h0000_0007, 32'h0000_0022, 1'b0};
        tab[5] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0};

        model_clear();
        m_misses = 0;

        // Reset state, with a fetch request present.
        rst = 1'b0; cpu_ce = 1'b1; cpu_addr = 32'd0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_inst", cpu_inst, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        $display("reset state checked");
        cpu_ce = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Cold miss, then the hit table on the same line.
        do_fetch(32'h0000_0000, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(tab[i].ce, tab[i].addr, 1'b0);
            chk("tab_inst", cpu_inst, tab[i].inst);
            chk("tab_stall", 32'(stall_req), 32'(tab[i].stall));
            chk("tab_mem_req", 32'(mem_req), 32'd0);
            chk("tab_miss_cnt", 32'(miss_cnt), sat_cnt(m_misses));
            $display("vector %0d ce=%0d addr=%h inst=%h stall=%0d", i, tab[i].ce, tab[i].addr, cpu_inst, stall_req);
        end

        // Slow memory, then the rest of that line hits.
        do_fetch(32'h0000_0020, 3);
        do_fetch(32'h0000_0024, 1);
        do_fetch(32'h0000_0028, 1);
        do_fetch(32'h0000_002C, 1);

        // Conflict eviction on index 0.
        do_fetch(32'h0000_0400, 1);
        do_fetch(32'h0000_0000, 1);
        do_fetch(32'h0000_0404, 1);

        // Flush after the 2nd ack: line lands invalid, refetched immediately.
        a = 32'h0000_0030;
        ack_period = 1;
        ack_q.delete();
        flushed = 1'b0;
        n_stall = 0;
        for (int c = 0; c < 60; c++) begin
            fl = (ack_q.size() == 2) && !flushed;
            if (fl) flushed = 1'b1;
            cycle(1'b1, a, fl);
            if (!stall_req) break;
            n_stall++;
        end
        model_clear();
        m_valid[3] = 1'b1;
        m_tag[3]   = 0;
        m_misses  += 2;
        chk("flush_stall", n_stall, 10);
        chk("flush_acks", ack_q.size(), 8);
        chk("flush_inst", cpu_inst, mem_word(a));
        chk("flush_miss_cnt", 32'(miss_cnt), sat_cnt(m_misses));
        if (ack_q.size() == 8) chk("flush_rebase", ack_q[4], a);
        $display("flush during refill addr=%h stall=%0d acks=%0d", a, n_stall, ack_q.size());
        do_fetch(32'h0000_0000, 1);

        // Async reset after the 1st ack of a refill.
        a = 32'h0000_0040;
        ack_q.delete();
        for (int c = 0; c < 20 && ack_q.size() < 1; c++) cycle(1'b1, a, 1'b0);
        chk("rst_seq_ack_seen", ack_q.size(), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_stall", 32'(stall_req), 32'd0);
        chk("arst_inst", cpu_inst, 32'd0);
        chk("arst_miss_cnt", 32'(miss_cnt), 32'd0);
        $display("async reset mid-refill addr=%h", a);
        cpu_ce = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        m_misses = 0;
        do_fetch(a, 1);

        // Random traffic over a small address pool.
        for (int n = 0; n < 200; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 8) begin
                cycle(1'b0, $urandom, 1'b0);
                chk("idle_inst", cpu_inst, 32'd0);
                chk("idle_stall", 32'(stall_req), 32'd0);
                $display("idle cycle ce=0");
            end else if (r < 12) begin
                cycle(1'b0, $urandom, 1'b1);
                model_clear();
                chk("flush_idle_stall", 32'(stall_req), 32'd0);
                $display("flush pulse");
            end else begin
                a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
                    (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
                do_fetch(a, $urandom_range(1, 3));
            end
        end
        cycle(1'b0, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
